// File: rtl/hex_reader.sv
// hex_reader: deserialises two active-low 7-segment digit patterns, low
// digit first and segment a first, and decodes them into one byte.
//
// Ports
//   clock        rising-edge system clock
//   resetn       asynchronous active-low reset
//   seg_in       serial segment bit (0 = segment lit)
//   seg_valid    seg_in is accepted on a rising edge while this is 1
//   frame_start  synchronous restart; the bit of the same cycle becomes bit 0
//   data_out     decoded byte {high nibble, low nibble}, held between frames
//   data_valid   one-cycle pulse when data_out is loaded
//   err          one-cycle pulse with data_valid when either digit is invalid
//   busy         high while a frame is partially received
//   frame_cnt    completed-frame counter, wraps 255 -> 0
//
// State table
//   state | meaning
//   IDLE  | no bits of the current frame received yet
//   LO    | receiving low digit, frame bits 0-6
//   HI    | receiving high digit, frame bits 7-13
module hex_reader (
  input  logic       clock,
  input  logic       resetn,
  input  logic       seg_in,
  input  logic       seg_valid,
  input  logic       frame_start,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       err,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [6:0] shift;
  logic [6:0] pattern;
  logic       armed;
  logic       accept;
  logic [3:0] lo_nib;
  logic       lo_bad;
  logic [3:0] dec_nib;
  logic       dec_bad;
  logic       lo_done;
  logic       frame_done;

  // Returns {invalid, nibble}; invalid patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Segment 0 arrives first, so bits shift in at the top; after seven
  // accepted bits the register holds {seg6..seg0}. The pattern includes the
  // bit being accepted this cycle so a digit is decoded on its 7th edge.
  assign pattern = {seg_in, shift[6:1]};
  assign accept  = seg_valid & armed;

  always_comb begin
    {dec_bad, dec_nib} = decode(pattern);
  end

  // State register. armed stays low through the edge on which resetn is
  // released so that edge cannot accept a bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 3'd0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
    end
  end

  // Next-state logic; cnt is the position within the current digit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (frame_start) begin
      state_nxt = accept ? LO : IDLE;
      cnt_nxt   = accept ? 3'd1 : 3'd0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          state_nxt = LO;
          cnt_nxt   = 3'd1;
        end
        LO: begin
          if (cnt == 3'd6) begin
            state_nxt = HI;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        HI: begin
          if (cnt == 3'd6) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Output/control decode. frame_start overrides completion of either digit.
  always_comb begin
    lo_done    = 1'b0;
    frame_done = 1'b0;
    if (accept && !frame_start && cnt == 3'd6) begin
      lo_done    = (state == LO);
      frame_done = (state == HI);
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift      <= 7'd0;
      lo_nib     <= 4'd0;
      lo_bad     <= 1'b0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      if (accept) begin
        shift <= pattern;
      end
      if (lo_done) begin
        lo_nib <= dec_nib;
        lo_bad <= dec_bad;
      end
      if (frame_done) begin
        data_out  <= {dec_nib, lo_nib};
        frame_cnt <= frame_cnt + 8'd1;
      end
      data_valid <= frame_done;
      err        <= frame_done & (lo_bad | dec_bad);
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_hex_reader.sv
module tb_hex_reader;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       seg_in = 1'b1;
  logic       seg_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       err;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  // Segment pattern for each hex digit, index = nibble.
  logic [6:0] seg_tab [16];

  hex_reader dut (
    .clock       (clock),
    .resetn      (resetn),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .frame_start (frame_start),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .err         (err),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (data_valid) pulses++;

  function automatic void model(input logic [6:0] p, output logic [3:0] nib, output logic bad);
    nib = 4'd0;
    bad = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (seg_tab[k] == p) begin
        nib = 4'(k);
        bad = 1'b0;
      end
    end
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic send_bit(input logic b);
    seg_in    = b;
    seg_valid = 1'b1;
    @(posedge clock); #1;
    seg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_range(input logic [6:0] p, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(p[i]);
  endtask

  task automatic send_frame(input logic [6:0] lo, input logic [6:0] hi);
    send_range(lo, 0, 6);
    send_range(hi, 0, 6);
  endtask

  task automatic restart_bit(input logic b);
    frame_start = 1'b1;
    send_bit(b);
    frame_start = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    idle(2);
    @(negedge clock);
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_frame_cnt: got %h want 00", frame_cnt); end
  endtask

  task automatic test_back_to_back;
    send_bit(1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_first: got %b want 1", busy); end
    send_range(7'h19, 1, 6);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_early_valid: got %b want 0", data_valid); end
    send_range(7'h30, 0, 6);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", data_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", err); end
    n_cmp++; if (data_out !== 8'h34) begin n_bad++; $display("FAIL b2b_data: got %h want 34", data_out); end
    n_cmp++; if (frame_cnt !== 8'h01) begin n_bad++; $display("FAIL b2b_cnt: got %h want 01", frame_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
    idle(1);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_pulse: got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'h34) begin n_bad++; $display("FAIL b2b_data_hold: got %h want 34", data_out); end
  endtask

  task automatic test_gaps;
    logic [13:0] bits;
    int p0;
    bits = {7'h0E, 7'h46};
    p0 = pulses;
    for (int i = 0; i < 14; i++) begin
      idle($urandom_range(0, 3));
      send_bit(bits[i]);
    end
    n_cmp++; if (data_out !== 8'hFC) begin n_bad++; $display("FAIL gaps_data: got %h want FC", data_out); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL gaps_err: got %b want 0", err); end
    idle(3);
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL gaps_pulses: got %0d want 1", pulses - p0); end
    n_cmp++; if (frame_cnt !== 8'h02) begin n_bad++; $display("FAIL gaps_cnt: got %h want 02", frame_cnt); end
  endtask

  task automatic test_invalid;
    send_frame(7'h7F, 7'h40);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL inv_valid: got %b want 1", data_valid); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err: got %b want 1", err); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL inv_data: got %h want 00", data_out); end
    n_cmp++; if (frame_cnt !== 8'h03) begin n_bad++; $display("FAIL inv_cnt: got %h want 03", frame_cnt); end
    idle(1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL inv_err_pulse: got %b want 0", err); end
  endtask

  task automatic test_restart;
    int p0;
    p0 = pulses;
    send_range(7'h12, 0, 6);
    send_range(7'h79, 0, 1);
    restart_bit(1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    n_cmp++; if (frame_cnt !== 8'h03) begin n_bad++; $display("FAIL rst_cnt_kept: got %h want 03", frame_cnt); end
    send_range(7'h08, 1, 6);
    send_range(7'h21, 0, 6);
    n_cmp++; if (data_out !== 8'hDA) begin n_bad++; $display("FAIL rst_data: got %h want DA", data_out); end
    n_cmp++; if (frame_cnt !== 8'h04) begin n_bad++; $display("FAIL rst_cnt: got %h want 04", frame_cnt); end
    idle(2);
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL rst_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_priority;
    int p0;
    p0 = pulses;
    send_range(7'h06, 0, 6);
    send_range(7'h06, 0, 5);
    restart_bit(1'b0);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL prio_valid: got %b want 0", data_valid); end
    n_cmp++; if (frame_cnt !== 8'h04) begin n_bad++; $display("FAIL prio_cnt: got %h want 04", frame_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL prio_busy: got %b want 1", busy); end
    n_cmp++; if (data_out !== 8'hDA) begin n_bad++; $display("FAIL prio_data_kept: got %h want DA", data_out); end
    send_range(7'h40, 1, 6);
    send_range(7'h79, 0, 6);
    n_cmp++; if (data_out !== 8'h10) begin n_bad++; $display("FAIL prio_next_data: got %h want 10", data_out); end
    n_cmp++; if (frame_cnt !== 8'h05) begin n_bad++; $display("FAIL prio_next_cnt: got %h want 05", frame_cnt); end
    idle(1);
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL prio_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_decode_all;
    logic [3:0] nib;
    logic       bad;
    for (int p = 0; p < 128; p++) begin
      model(7'(p), nib, bad);
      send_frame(7'(p), 7'h40);
      n_cmp++;
      if (data_out !== {4'h0, nib} || err !== bad || data_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL decode_%02h: got data %h err %b valid %b want data %h err %b valid 1",
                 p, data_out, err, data_valid, {4'h0, nib}, bad);
      end
    end
  endtask

  task automatic test_wrap_and_reset;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame(seg_tab[i % 16], seg_tab[(i + 3) % 16]);
      if (i == 254) begin
        n_cmp++; if (frame_cnt !== 8'hFF) begin n_bad++; $display("FAIL wrap_cnt_255: got %h want FF", frame_cnt); end
      end
    end
    n_cmp++; if (frame_cnt !== 8'h00) begin n_bad++; $display("FAIL wrap_cnt_0: got %h want 00", frame_cnt); end
    n_cmp++; if (data_out !== 8'h2F) begin n_bad++; $display("FAIL wrap_data: got %h want 2F", data_out); end
    send_frame(seg_tab[5], seg_tab[9]);
    send_range(7'h24, 0, 4);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset_outputs: got data %h valid %b err %b busy %b cnt %h want all 0",
               data_out, data_valid, err, busy, frame_cnt);
    end
    idle(2);
    @(negedge clock);
    resetn = 1'b1;
    idle(2);
    send_frame(7'h02, 7'h78);
    n_cmp++; if (data_out !== 8'h76) begin n_bad++; $display("FAIL midreset_data: got %h want 76", data_out); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b want 0", err); end
    n_cmp++; if (frame_cnt !== 8'h01) begin n_bad++; $display("FAIL midreset_cnt: got %h want 01", frame_cnt); end
  endtask

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_invalid();
    test_restart();
    test_priority();
    test_decode_all();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_reader.md
HEX_READER -- requirements
Module: hex_reader

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 seg_in  input  1  serial segment bit; active-low, so 0 means the segment is lit.
REQ-005 seg_valid  input  1  seg_in is accepted on a rising edge only while this is 1.
REQ-006 frame_start  input  1  synchronous restart of the frame.
REQ-007 data_out  output  8  decoded byte {high nibble, low nibble}.
REQ-008 data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-009 err  output  1  one-cycle pulse, coincident with data_valid, when either digit pattern is invalid.
REQ-010 busy  output  1  high while a frame is partially received.
REQ-011 frame_cnt  output  8  count of completed frames.

Function
REQ-012 A frame SHALL be 14 accepted bits: the low digit first, then the high digit.
REQ-013 Each digit SHALL be 7 bits in order segment 0 (a) first through segment 6 (g); the pattern is {seg6..seg0}.
REQ-014 Decode table (pattern hex -> nibble) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-015 Any other 7-bit pattern SHALL be invalid; it decodes to nibble 0 and marks the frame invalid.
REQ-016 The state machine SHALL have the states IDLE, LO (receiving bits 0-6) and HI (receiving bits 7-13).
REQ-017 IDLE->LO SHALL occur on the first accepted bit, which is stored as bit 0.
REQ-018 LO->HI SHALL occur on the edge that accepts the 7th bit; the low nibble and its validity are registered on that same edge.
REQ-019 HI->IDLE SHALL occur on the edge that accepts the 14th bit. On that same edge the block SHALL load data_out, set data_valid to 1, set err to (either digit invalid), and increment frame_cnt.
REQ-020 data_valid and err SHALL be 1 for exactly one cycle; data_out SHALL hold its value until the next completed frame.
REQ-021 Latency SHALL be 0 cycles: the outputs are visible in the cycle after the edge that accepts the 14th bit.
REQ-022 seg_valid=0 SHALL hold all state; gaps of any length between bits are permitted.
REQ-023 frame_start=1 SHALL discard the partial frame and clear the bit count. If seg_valid=1 in the same cycle, that bit SHALL be accepted as bit 0 of the new frame (state LO, count 1); otherwise the state is IDLE.
REQ-024 frame_start SHALL NOT alter data_out or frame_cnt.
REQ-025 frame_start on the same edge as a 14th bit SHALL take priority: no data_valid, no frame_cnt increment.
REQ-026 frame_cnt SHALL wrap from 255 to 0.
REQ-027 busy SHALL be 1 exactly when the state is LO or HI.
REQ-028 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-029 resetn=0 SHALL immediately force: state IDLE, bit count 0, data_out=00, data_valid=0, err=0, busy=0, frame_cnt=00.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first accepted bit after release is bit 0.
REQ-031 Release of reset SHALL be synchronous-safe: no bit is accepted on the edge where resetn rises.

Verification
REQ-032 Reset, then send patterns 19 then 30 back-to-back -> data_out=34, data_valid and err pulse 1 and 0, frame_cnt=01, busy=0 after.
REQ-033 Send 46 then 0E with random seg_valid gaps -> data_out=FC, single data_valid pulse, err=0.
REQ-034 Send 7F then 40 -> data_out=00, err=1 with data_valid, frame_cnt increments.
REQ-035 Send 9 bits, assert frame_start with seg_valid=1, then send 13 more bits forming 08,21 -> data_out=DA, exactly one data_valid.
REQ-036 Send 256 valid frames -> frame_cnt=00; then drop resetn mid-frame -> all outputs 0 immediately, next full frame decodes correctly.
REQ-037 Compare all 128 low-digit patterns against a model -> nibble and err match REQ-014 and REQ-015.
